// File: rtl/image_loader_pkg.sv
// Shared definitions for the boot image loader: FSM states, the default sync
// byte and the byte layout of an image record.
package image_loader_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;

  // Record layout: SYNC, ADDR_L, ADDR_H, LEN_L, LEN_H, payload..., CSUM
  localparam int unsigned OFS_SYNC    = 0;
  localparam int unsigned OFS_ADDR_L  = 1;
  localparam int unsigned OFS_ADDR_H  = 2;
  localparam int unsigned OFS_LEN_L   = 3;
  localparam int unsigned OFS_LEN_H   = 4;
  localparam int unsigned OFS_PAYLOAD = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_L,
    ST_ADDR_H,
    ST_LEN_L,
    ST_LEN_H,
    ST_DATA,
    ST_CSUM,
    ST_RUN
  } state_e;

endpackage

// File: rtl/image_loader.sv
// Byte-stream boot loader: parses framed records, writes payload bytes into
// main memory, checks the record checksum and releases the CPU on a go record.
module image_loader
  import image_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter logic [7:0]  SYNC   = SYNC_BYTE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              run,
  output logic [15:0]       start_pc,
  output logic              busy,
  output logic              error,
  output logic [7:0]        frame_count
);

  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic              go_q, go_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              run_q, run_d;
  logic [15:0]       start_pc_q, start_pc_d;
  logic              error_q, error_d;
  logic [7:0]        frame_count_q, frame_count_d;

  logic              accept;
  logic [7:0]        sum_next;

  assign in_ready = (state_q != ST_RUN);
  assign accept   = in_valid && in_ready;
  assign sum_next = sum_q + in_data;

  // NOTE: every _d is given its hold value first so no path through the case
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    sum_d         = sum_q;
    go_d          = go_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    run_d         = run_q;
    start_pc_d    = start_pc_q;
    error_d       = error_q;
    frame_count_d = frame_count_q;

    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_data == SYNC) begin
            state_d = ST_ADDR_L;
            error_d = 1'b0;
            sum_d   = 8'h00;
          end
        end
        ST_ADDR_L: begin
          addr_d[7:0] = in_data;
          sum_d       = sum_next;
          state_d     = ST_ADDR_H;
        end
        ST_ADDR_H: begin
          addr_d[15:8] = in_data;
          sum_d        = sum_next;
          state_d      = ST_LEN_L;
        end
        ST_LEN_L: begin
          len_d[7:0] = in_data;
          sum_d      = sum_next;
          state_d    = ST_LEN_H;
        end
        ST_LEN_H: begin
          len_d[15:8] = in_data;
          sum_d       = sum_next;
          go_d        = ({in_data, len_q[7:0]} == 16'd0);
          state_d     = go_d ? ST_CSUM : ST_DATA;
        end
        ST_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q[ADDR_W-1:0];
          mem_wdata_d = in_data;
          addr_d      = addr_q + 16'd1;
          len_d       = len_q - 16'd1;
          sum_d       = sum_next;
          if (len_q == 16'd1) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          sum_d   = sum_next;
          state_d = ST_IDLE;
          if (sum_next != 8'h00) begin
            error_d = 1'b1;
          end else if (go_q) begin
            // A go record carries no payload, so addr_q still holds ADDR.
            start_pc_d = addr_q;
            run_d      = 1'b1;
            state_d    = ST_RUN;
          end else begin
            frame_count_d = frame_count_q + 8'd1;
          end
        end
        ST_RUN: state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      sum_q         <= '0;
      go_q          <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      run_q         <= 1'b0;
      start_pc_q    <= '0;
      error_q       <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      sum_q         <= sum_d;
      go_q          <= go_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      run_q         <= run_d;
      start_pc_q    <= start_pc_d;
      error_q       <= error_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign run         = run_q;
  assign start_pc    = start_pc_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_RUN);
  assign error       = error_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: directed record table, randomized
// records against a record-level reference model, and reset/go corner cases.
module tb_image_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        run;
  logic [15:0] start_pc;
  logic        busy;
  logic        error;
  logic [7:0]  frame_count;

  image_loader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .run         (run),
    .start_pc    (start_pc),
    .busy        (busy),
    .error       (error),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  wr_t act_q[$];
  wr_t exp_q[$];

  always @(negedge clock)
    if (reset_n && mem_we) act_q.push_back('{mem_addr, mem_wdata, cyc});

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  pl[$];
  logic [7:0]  fc_exp  = 8'd0;
  logic        err_exp = 1'b0;
  logic        run_exp = 1'b0;
  logic [15:0] pc_exp  = 16'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called and returns at posedge+1; acc is the cycle in which the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int max_gap, output int acc);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin @(posedge clock); #1; end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clock);
    acc = cyc;
    check("in_ready_while_sending", in_ready, 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic compare_writes();
    int n;
    check("wr_count", 64'(act_q.size()), 64'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("wr_addr", act_q[i].addr, exp_q[i].addr);
      check("wr_data", act_q[i].data, exp_q[i].data);
      check("wr_cycle", 64'(act_q[i].cyc), 64'(exp_q[i].cyc));
    end
    act_q.delete();
    exp_q.delete();
  endtask

  // Sends one record with payload pl; the checksum is derived from the record
  // rule unless use_csum forces a given byte. Updates and checks the model.
  task automatic send_record(input logic [15:0] addr, input logic use_csum,
                             input logic [7:0] csum_in, input int max_gap);
    logic [15:0] len;
    logic [7:0]  sum, csum, tot;
    logic        good;
    int          acc;
    len = 16'(pl.size());
    sum = addr[7:0] + addr[15:8] + len[7:0] + len[15:8];
    foreach (pl[i]) sum = sum + pl[i];
    csum = use_csum ? csum_in : (8'h00 - sum);
    tot  = sum + csum;
    good = (tot == 8'h00);

    send_byte(8'hA5, max_gap, acc);
    check("busy_after_sync", busy, 1'b1);
    check("error_cleared_at_sync", error, 1'b0);
    send_byte(addr[7:0], max_gap, acc);
    send_byte(addr[15:8], max_gap, acc);
    send_byte(len[7:0], max_gap, acc);
    send_byte(len[15:8], max_gap, acc);
    foreach (pl[i]) begin
      send_byte(pl[i], max_gap, acc);
      exp_q.push_back('{12'(addr + 16'(i)), pl[i], acc + 1});
    end
    send_byte(csum, max_gap, acc);
    repeat (2) begin @(posedge clock); #1; end

    err_exp = !good;
    if (good && len != 16'd0) fc_exp = fc_exp + 8'd1;
    if (good && len == 16'd0) begin
      run_exp = 1'b1;
      pc_exp  = addr;
    end
    compare_writes();
    check("error", error, err_exp);
    check("frame_count", frame_count, fc_exp);
    check("run", run, run_exp);
    check("start_pc", start_pc, pc_exp);
    check("busy_after_record", busy, 1'b0);
    check("in_ready_after_record", in_ready, !run_exp);
  endtask

  task automatic do_reset();
    act_q.delete();
    exp_q.delete();
    reset_n = 1'b0;
    #2;
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 12'h000);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_run", run, 1'b0);
    check("rst_start_pc", start_pc, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_frame_count", frame_count, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;
    fc_exp  = 8'd0;
    err_exp = 1'b0;
    run_exp = 1'b0;
    pc_exp  = 16'd0;
    @(posedge clock); #1;
  endtask

  typedef struct {
    int          n_junk;
    logic [7:0]  junk0, junk1, junk2;
    logic [15:0] addr;
    int          len;
    logic [7:0]  p0, p1, p2;
    logic [7:0]  csum;
    int          max_gap;
    logic        exp_err;
    logic [7:0]  exp_fc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    // Directed records: bytes and the expected error/frame_count after each.
    vecs[0] = '{0, 8'h00, 8'h00, 8'h00, 16'h0100, 3, 8'h11, 8'h22, 8'h33, 8'h96, 0, 1'b0, 8'd1};
    vecs[1] = '{0, 8'h00, 8'h00, 8'h00, 16'h0100, 3, 8'h11, 8'h22, 8'h33, 8'h97, 0, 1'b1, 8'd1};
    vecs[2] = '{0, 8'h00, 8'h00, 8'h00, 16'h0100, 3, 8'h11, 8'h22, 8'h33, 8'h96, 0, 1'b0, 8'd2};
    vecs[3] = '{3, 8'h00, 8'hFF, 8'h5A, 16'h0100, 3, 8'h11, 8'h22, 8'h33, 8'h96, 0, 1'b0, 8'd3};
    vecs[4] = '{0, 8'h00, 8'h00, 8'h00, 16'h0FFF, 2, 8'hAA, 8'hBB, 8'h00, 8'h47, 0, 1'b1, 8'd3};
    vecs[5] = '{0, 8'h00, 8'h00, 8'h00, 16'h0100, 3, 8'h11, 8'h22, 8'h33, 8'h96, 2, 1'b0, 8'd4};
    vecs[6] = '{0, 8'h00, 8'h00, 8'h00, 16'h0FFF, 2, 8'hAA, 8'hBB, 8'h00, 8'h8B, 1, 1'b0, 8'd5};

    #1;
    do_reset();

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].n_junk > 0) send_byte(vecs[v].junk0, 0, acc);
      if (vecs[v].n_junk > 1) send_byte(vecs[v].junk1, 0, acc);
      if (vecs[v].n_junk > 2) send_byte(vecs[v].junk2, 0, acc);
      pl.delete();
      if (vecs[v].len > 0) pl.push_back(vecs[v].p0);
      if (vecs[v].len > 1) pl.push_back(vecs[v].p1);
      if (vecs[v].len > 2) pl.push_back(vecs[v].p2);
      send_record(vecs[v].addr, 1'b1, vecs[v].csum, vecs[v].max_gap);
      check("vec_error", error, vecs[v].exp_err);
      check("vec_frame_count", frame_count, vecs[v].exp_fc);
    end

    // Random data records, enough good ones to wrap frame_count past 255.
    for (int r = 0; r < 320; r++) begin
      int          nj, ln;
      logic [7:0]  j;
      logic [15:0] a;
      logic        bad;
      nj = $urandom_range(2, 0);
      for (int k = 0; k < nj; k++) begin
        j = 8'($urandom_range(255, 0));
        if (j == 8'hA5) j = 8'h5A;
        send_byte(j, 1, acc);
      end
      ln = ($urandom_range(9, 0) == 0) ? int'($urandom_range(20, 7)) : int'($urandom_range(6, 1));
      a  = 16'($urandom_range(65535, 0));
      pl.delete();
      for (int k = 0; k < ln; k++) pl.push_back(8'($urandom_range(255, 0)));
      bad = ($urandom_range(9, 0) == 0);
      if (bad) begin
        logic [7:0] s;
        s = a[7:0] + a[15:8] + 8'(ln);
        foreach (pl[i]) s = s + pl[i];
        send_record(a, 1'b1, 8'h00 - s + 8'(1 + $urandom_range(254, 0)), 2);
      end else begin
        send_record(a, 1'b0, 8'h00, $urandom_range(2, 0));
      end
    end

    // Reset after LEN_L: record abandoned, no writes, outputs back to reset values.
    send_byte(8'hA5, 0, acc);
    send_byte(8'h00, 0, acc);
    send_byte(8'h01, 0, acc);
    send_byte(8'h03, 0, acc);
    do_reset();
    repeat (4) begin @(posedge clock); #1; end
    check("no_write_after_reset", 64'(act_q.size()), 64'd0);
    check("idle_after_reset", busy, 1'b0);
    pl.delete();
    pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    send_record(16'h0100, 1'b1, 8'h96, 2);
    check("recover_frame_count", frame_count, 8'd1);

    // Reset right after a data byte: the registered write must be dropped.
    send_byte(8'hA5, 0, acc);
    send_byte(8'h00, 0, acc);
    send_byte(8'h02, 0, acc);
    send_byte(8'h02, 0, acc);
    send_byte(8'h00, 0, acc);
    send_byte(8'h11, 0, acc);
    do_reset();
    repeat (3) begin @(posedge clock); #1; end
    check("pending_write_dropped", 64'(act_q.size()), 64'd0);

    // Bad go record: error set, CPU stays held.
    pl.delete();
    send_record(16'h1234, 1'b1, 8'hBB, 0);
    check("bad_go_run", run, 1'b0);
    check("bad_go_error", error, 1'b1);

    // Good go record releases the CPU.
    send_record(16'h0100, 1'b1, 8'hFF, 0);
    check("go_run", run, 1'b1);
    check("go_start_pc", start_pc, 16'h0100);

    // RUN is terminal: bytes are refused and nothing is written.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("run_in_ready", in_ready, 1'b0);
      check("run_sticky", run, 1'b1);
      check("run_not_busy", busy, 1'b0);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("run_no_writes", 64'(act_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
